// File: rtl/chip_dac_frame_decoder.sv
// Receive-side decoder for the serial DAC-programming pins (chip_rst, chip_clk, chip_data_in).
// Oversamples the pins on the system clock, decodes start / 3-bit address / 8-bit level /
// stop frames (LSB first) and reports each good frame and each error with a one-cycle strobe.
module chip_dac_frame_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned TO_W           = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       chip_rst_i,
    input  logic       chip_clk_i,
    input  logic       chip_data_in_i,
    output logic [2:0] dac_add_o,
    output logic [7:0] dac_level_o,
    output logic       frame_valid_o,
    output logic [7:0] frame_count_o,
    output logic       framing_err_o,
    output logic       timeout_err_o,
    output logic       abort_rst_o,
    output logic       busy_o,
    output logic       chip_in_reset_o
);

    localparam logic [TO_W-1:0] ToLimit = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] ToMax   = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        StResetHold,
        StIdle,
        StAddr,
        StLevel,
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic            rst_s1_q, rst_s2_q;
    logic            clk_s1_q, clk_s2_q, clk_h_q;
    logic            dat_s1_q, dat_s2_q;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]      shift_add_q, shift_add_d;
    logic [7:0]      shift_lvl_q, shift_lvl_d;
    logic [2:0]      dac_add_q, dac_add_d;
    logic [7:0]      dac_level_q, dac_level_d;
    logic [7:0]      frame_count_q, frame_count_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            terr_q, terr_d;
    logic            abort_q, abort_d;
    logic            fall;
    logic            busy;

    // Falling edge of the synchronised bit clock; sync flops reset low so no edge fires at reset.
    assign fall = ~clk_s2_q & clk_h_q;

    // State register, synchronisers and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StResetHold;
            rst_s1_q      <= 1'b0;
            rst_s2_q      <= 1'b0;
            clk_s1_q      <= 1'b0;
            clk_s2_q      <= 1'b0;
            clk_h_q       <= 1'b0;
            dat_s1_q      <= 1'b0;
            dat_s2_q      <= 1'b0;
            bit_cnt_q     <= '0;
            shift_add_q   <= '0;
            shift_lvl_q   <= '0;
            dac_add_q     <= '0;
            dac_level_q   <= '0;
            frame_count_q <= '0;
            to_q          <= '0;
            valid_q       <= 1'b0;
            ferr_q        <= 1'b0;
            terr_q        <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_s1_q      <= chip_rst_i;
            rst_s2_q      <= rst_s1_q;
            clk_s1_q      <= chip_clk_i;
            clk_s2_q      <= clk_s1_q;
            clk_h_q       <= clk_s2_q;
            dat_s1_q      <= chip_data_in_i;
            dat_s2_q      <= dat_s1_q;
            bit_cnt_q     <= bit_cnt_d;
            shift_add_q   <= shift_add_d;
            shift_lvl_q   <= shift_lvl_d;
            dac_add_q     <= dac_add_d;
            dac_level_q   <= dac_level_d;
            frame_count_q <= frame_count_d;
            to_q          <= to_d;
            valid_q       <= valid_d;
            ferr_q        <= ferr_d;
            terr_q        <= terr_d;
            abort_q       <= abort_d;
        end
    end

    // Next-state, frame assembly, timeout counter and strobe generation.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_add_d   = shift_add_q;
        shift_lvl_d   = shift_lvl_q;
        dac_add_d     = dac_add_q;
        dac_level_d   = dac_level_q;
        frame_count_d = frame_count_q;
        valid_d       = 1'b0;
        ferr_d        = 1'b0;
        terr_d        = 1'b0;
        abort_d       = 1'b0;

        // Saturating gap counter; only advances while a frame is in progress.
        to_d = to_q;
        if (fall) begin
            to_d = '0;
        end else if (busy && (to_q != ToMax)) begin
            to_d = to_q + TO_W'(1);
        end

        // chip_rst wins over any bit or timeout in the same cycle.
        if (!rst_s2_q) begin
            state_d = StResetHold;
            abort_d = busy;
        end else if (busy && !fall && (to_q >= ToLimit)) begin
            terr_d  = 1'b1;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StResetHold: state_d = StIdle;
                StIdle: begin
                    if (fall && !dat_s2_q) begin
                        state_d   = StAddr;
                        bit_cnt_d = '0;
                    end
                end
                StAddr: begin
                    if (fall) begin
                        shift_add_d[bit_cnt_q[1:0]] = dat_s2_q;
                        if (bit_cnt_q == 3'd2) begin
                            state_d   = StLevel;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                StLevel: begin
                    if (fall) begin
                        shift_lvl_d[bit_cnt_q] = dat_s2_q;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    if (fall) begin
                        // A bad stop bit is not reused as a start bit.
                        state_d = StIdle;
                        if (dat_s2_q) begin
                            dac_add_d     = shift_add_q;
                            dac_level_d   = shift_lvl_q;
                            frame_count_d = frame_count_q + 8'd1;
                            valid_d       = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                default: state_d = StResetHold;
            endcase
        end
    end

    // Output decode from registered state.
    always_comb begin
        busy            = (state_q == StAddr) || (state_q == StLevel) || (state_q == StStop);
        busy_o          = busy;
        chip_in_reset_o = (state_q == StResetHold);
        dac_add_o       = dac_add_q;
        dac_level_o     = dac_level_q;
        frame_count_o   = frame_count_q;
        frame_valid_o   = valid_q;
        framing_err_o   = ferr_q;
        timeout_err_o   = terr_q;
        abort_rst_o     = abort_q;
    end

endmodule

// File: tb/tb_chip_dac_frame_decoder.sv
// Directed bench for chip_dac_frame_decoder: table of frames plus hand-written corner sequences.
module tb_chip_dac_frame_decoder;

    localparam int Timeout = 10000;

    logic       clk, rst, chip_rst, chip_clk, chip_data;
    logic [2:0] dac_add;
    logic [7:0] dac_level, frame_count;
    logic       frame_valid, framing_err, timeout_err, abort_rst, busy, chip_in_reset;

    int checks = 0;
    int failures = 0;
    int n_valid = 0, n_ferr = 0, n_terr = 0, n_abort = 0, n_multi = 0;
    int exp_cnt = 0;

    chip_dac_frame_decoder #(
        .TIMEOUT_CYCLES(Timeout),
        .TO_W          (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .chip_rst_i     (chip_rst),
        .chip_clk_i     (chip_clk),
        .chip_data_in_i (chip_data),
        .dac_add_o      (dac_add),
        .dac_level_o    (dac_level),
        .frame_valid_o  (frame_valid),
        .frame_count_o  (frame_count),
        .framing_err_o  (framing_err),
        .timeout_err_o  (timeout_err),
        .abort_rst_o    (abort_rst),
        .busy_o         (busy),
        .chip_in_reset_o(chip_in_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe-cycle counters; a stuck strobe shows up as an extra count.
    always @(posedge clk) begin
        n_valid <= n_valid + int'(frame_valid);
        n_ferr  <= n_ferr + int'(framing_err);
        n_terr  <= n_terr + int'(timeout_err);
        n_abort <= n_abort + int'(abort_rst);
        if (int'(frame_valid) + int'(framing_err) + int'(timeout_err) + int'(abort_rst) > 1)
            n_multi <= n_multi + 1;
    end

    typedef struct {
        logic [2:0] addr;
        logic [7:0] lvl;
        logic       stop;
        logic [2:0] e_add;
        logic [7:0] e_lvl;
        int         e_valid;
        int         e_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Rising edge, data launched shortly after, falling edge mid-bit.
    task automatic bit_start(input logic b);
        @(negedge clk) chip_clk = 1'b1;
        repeat (2) @(negedge clk);
        chip_data = b;
        repeat (4) @(negedge clk);
        chip_clk = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_start(b);
        repeat (5) @(negedge clk);
    endtask

    task automatic send_head(input logic [2:0] a, input logic [7:0] l, input int nlvl);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(a[i]);
        for (int i = 0; i < nlvl; i++) send_bit(l[i]);
    endtask

    task automatic send_frame(input logic [2:0] a, input logic [7:0] l, input logic stop);
        send_head(a, l, 8);
        send_bit(stop);
    endtask

    initial begin
        int v0, f0, t0, a0, n;
        logic [7:0] lv;

        vecs[0] = '{3'd5, 8'hA3, 1'b1, 3'd5, 8'hA3, 1, 0};
        vecs[1] = '{3'd2, 8'h00, 1'b1, 3'd2, 8'h00, 1, 0};
        vecs[2] = '{3'd7, 8'hFF, 1'b1, 3'd7, 8'hFF, 1, 0};
        vecs[3] = '{3'd1, 8'h5A, 1'b1, 3'd1, 8'h5A, 1, 0};
        vecs[4] = '{3'd4, 8'h3C, 1'b0, 3'd1, 8'h5A, 0, 1};
        vecs[5] = '{3'd6, 8'h81, 1'b1, 3'd6, 8'h81, 1, 0};

        rst = 1'b1; chip_rst = 1'b0; chip_clk = 1'b0; chip_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_reset", chip_in_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_add", dac_add, 0);
        chk("rst_valid", frame_valid, 0);
        rst = 1'b0;

        // Chip reset preamble: three bits with chip_rst low.
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("pre_in_reset", chip_in_reset, 1);
        chip_rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_released", chip_in_reset, 0);
        chk("pre_busy", busy, 0);

        // Table-driven frames, one idle bit after each.
        for (int k = 0; k < 6; k++) begin
            v0 = n_valid; f0 = n_ferr;
            send_frame(vecs[k].addr, vecs[k].lvl, vecs[k].stop);
            send_bit(1'b1);
            repeat (3) @(negedge clk);
            exp_cnt += vecs[k].e_valid;
            chk($sformatf("v%0d_valid", k), n_valid - v0, vecs[k].e_valid);
            chk($sformatf("v%0d_ferr", k), n_ferr - f0, vecs[k].e_ferr);
            chk($sformatf("v%0d_add", k), dac_add, vecs[k].e_add);
            chk($sformatf("v%0d_lvl", k), dac_level, vecs[k].e_lvl);
            chk($sformatf("v%0d_cnt", k), frame_count, exp_cnt);
            chk($sformatf("v%0d_busy", k), busy, 0);
        end
        chk("tbl_no_terr", n_terr, 0);
        chk("tbl_no_abort", n_abort, 0);

        // Latency: frame_valid on the 3rd rising clk after the raw stop-bit fall, one cycle wide.
        send_head(3'd0, 8'h77, 8);
        bit_start(1'b1);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (frame_valid) begin n = i; break; end
        end
        chk("lat_edges", n, 3);
        @(posedge clk); #1;
        chk("lat_width", frame_valid, 0);
        exp_cnt++;
        repeat (5) @(negedge clk);
        chk("lat_lvl", dac_level, 8'h77);

        // chip_rst abort after the 5th level bit.
        v0 = n_valid; a0 = n_abort;
        send_head(3'd3, 8'hEE, 5);
        chk("ab_busy_before", busy, 1);
        @(negedge clk) chip_rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("ab_strobe", n_abort - a0, 1);
        chk("ab_in_reset", chip_in_reset, 1);
        chk("ab_busy", busy, 0);
        chk("ab_no_valid", n_valid - v0, 0);
        chk("ab_add_hold", dac_add, 0);
        chk("ab_lvl_hold", dac_level, 8'h77);
        chk("ab_cnt_hold", frame_count, exp_cnt);
        chip_rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("ab_released", chip_in_reset, 0);
        send_frame(3'd3, 8'h11, 1'b1);
        send_bit(1'b1);
        exp_cnt++;
        chk("ab_next_add", dac_add, 3);
        chk("ab_next_lvl", dac_level, 8'h11);

        // chip_clk stalls mid-address.
        t0 = n_terr; v0 = n_valid;
        send_bit(1'b0);
        bit_start(1'b1);
        n = 0;
        for (int i = 1; i <= 12000; i++) begin
            @(posedge clk); #1;
            if (timeout_err) begin n = i; break; end
        end
        chk("to_edges", n, Timeout + 3);
        repeat (4) @(negedge clk);
        chk("to_strobe", n_terr - t0, 1);
        chk("to_busy", busy, 0);
        chk("to_not_reset", chip_in_reset, 0);
        chk("to_no_valid", n_valid - v0, 0);
        chk("to_lvl_hold", dac_level, 8'h11);
        send_frame(3'd5, 8'hC3, 1'b1);
        send_bit(1'b1);
        exp_cnt++;
        chk("to_next_add", dac_add, 5);
        chk("to_next_lvl", dac_level, 8'hC3);
        chk("to_next_cnt", frame_count, exp_cnt);

        // System reset mid-level: outputs clear immediately.
        send_head(3'd6, 8'h99, 3);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("mr_add", dac_add, 0);
        chk("mr_lvl", dac_level, 0);
        chk("mr_cnt", frame_count, 0);
        chk("mr_busy", busy, 0);
        chk("mr_in_reset", chip_in_reset, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        repeat (6) @(negedge clk);
        chk("mr_released", chip_in_reset, 0);

        // Back-to-back frames up to the counter wrap.
        for (int i = 0; i < 255; i++) begin
            lv = i[7:0];
            send_frame(lv[2:0], lv, 1'b1);
        end
        repeat (3) @(negedge clk);
        chk("wrap_255", frame_count, 255);
        chk("wrap_lvl", dac_level, 8'hFE);
        send_frame(3'd2, 8'h42, 1'b1);
        repeat (3) @(negedge clk);
        chk("wrap_0", frame_count, 0);
        chk("wrap_last_lvl", dac_level, 8'h42);
        chk("one_strobe", n_multi, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
